saradc_11b_dig_overs_acc: RTL and testbench

Oversampling accumulator downstream of the SAR-ADC digital FSM. It consumes each conversion result with its end-of-conversion pulse and sums 1, 2, 4 or 8 consecutive results as selected by `overs_cfg`. It then delivers the rounded average, with its own end-of-conversion pulse, to the digital top for register capture.

---
 rtl/saradc_11b_dig_pkg.sv | 45 ++++
 rtl/saradc_11b_dig_overs_acc_if.sv | 32 +++
 rtl/saradc_11b_dig_overs_acc.sv | 74 +++++++
 tb/tb_saradc_11b_dig_overs_acc.sv | 125 ++++++++++++
 4 files changed

// File: rtl/saradc_11b_dig_pkg.sv
// Shared types for the SAR-ADC digital slice.
// Oversampling ratio codes, accumulator state and datapath widths.
package saradc_11b_dig_pkg;

  localparam int RESULT_W = 11;
  localparam int ACC_W    = RESULT_W + 3;

  typedef enum logic [1:0] {
    OVERS_1 = 2'd0,
    OVERS_2 = 2'd1,
    OVERS_4 = 2'd2,
    OVERS_8 = 2'd3
  } overs_e;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } acc_state_e;

  function automatic logic [3:0] n_samples(
    input overs_e n
  );
    unique case (n)
      OVERS_1: n_samples = 4'd1;
      OVERS_2: n_samples = 4'd2;
      OVERS_4: n_samples = 4'd4;
      OVERS_8: n_samples = 4'd8;
      default: n_samples = 4'd1;
    endcase
  endfunction

  // Half an LSB of the averaged result, for round-half-up.
  function automatic logic [3:0] rnd_off(
    input overs_e n
  );
    unique case (n)
      OVERS_1: rnd_off = 4'd0;
      OVERS_2: rnd_off = 4'd1;
      OVERS_4: rnd_off = 4'd2;
      OVERS_8: rnd_off = 4'd4;
      default: rnd_off = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/saradc_11b_dig_overs_acc_if.sv
// Conversion-result stream into and averaged stream out of the
// oversampling accumulator.
interface saradc_11b_dig_overs_acc_if #(
  parameter int RESULT_MSB = 10
);

  logic                eoc_i;
  logic [RESULT_MSB:0] result_i;
  logic                eoc_o;
  logic [RESULT_MSB:0] result_o;
  logic                busy_o;
  logic [2:0]          smp_cnt_o;

  modport master (
    output eoc_i,
    output result_i,
    input  eoc_o,
    input  result_o,
    input  busy_o,
    input  smp_cnt_o
  );

  modport slave (
    input  eoc_i,
    input  result_i,
    output eoc_o,
    output result_o,
    output busy_o,
    output smp_cnt_o
  );

endinterface

// File: rtl/saradc_11b_dig_overs_acc.sv
// Sums 1/2/4/8 consecutive SAR results and emits the
// round-half-up average with its own end-of-conversion pulse.
module saradc_11b_dig_overs_acc
  import saradc_11b_dig_pkg::*;
#(
  parameter int RESULT_MSB = RESULT_W - 1,
  parameter int ACC_MSB    = RESULT_MSB + 3
) (
  input  logic       clk_i,
  input  logic       res_n_i,
  input  logic       clr_i,
  input  logic [1:0] overs_cfg_i,
  saradc_11b_dig_overs_acc_if.slave bus
);

  localparam int AW = ACC_MSB + 1;
  localparam int RW = RESULT_MSB + 1;

  acc_state_e    state;
  overs_e        n_lat;
  overs_e        n_sel;
  logic [ACC_MSB:0] sum;
  logic [ACC_MSB:0] sum_nxt;
  logic [ACC_MSB:0] rounded;
  logic [RESULT_MSB:0] avg;
  logic [2:0]    cnt;
  logic [3:0]    cnt_nxt;
  logic          done;

  // Ratio comes from the live config only on a sequence's first sample.
  always_comb begin
    n_sel   = (state == IDLE) ? overs_e'(overs_cfg_i) : n_lat;
    sum_nxt = ((state == IDLE) ? '0 : sum) + AW'(bus.result_i);
    cnt_nxt = ((state == IDLE) ? 4'd0 : {1'b0, cnt}) + 4'd1;
    done    = (cnt_nxt == n_samples(n_sel));
    rounded = sum_nxt + AW'(rnd_off(n_sel));
    avg     = RW'(rounded >> n_sel);
  end

  always_ff @(posedge clk_i) begin
    if (!res_n_i) begin
      state        <= IDLE;
      n_lat        <= OVERS_1;
      sum          <= '0;
      cnt          <= '0;
      bus.eoc_o    <= 1'b0;
      bus.result_o <= '0;
    end else begin
      bus.eoc_o <= 1'b0;
      if (clr_i) begin
        state <= IDLE;
        sum   <= '0;
        cnt   <= '0;
      end else if (bus.eoc_i) begin
        n_lat <= n_sel;
        if (done) begin
          state        <= IDLE;
          sum          <= '0;
          cnt          <= '0;
          bus.eoc_o    <= 1'b1;
          bus.result_o <= avg;
        end else begin
          state <= ACC;
          sum   <= sum_nxt;
          cnt   <= cnt_nxt[2:0];
        end
      end
    end
  end

  assign bus.busy_o    = (state == ACC);
  assign bus.smp_cnt_o = cnt;

endmodule

// File: tb/tb_saradc_11b_dig_overs_acc.sv
// Directed plus random stimulus against a sample-list average model.
// Every cycle compares all four outputs.
module tb_saradc_11b_dig_overs_acc;

  logic       clk = 1'b0;
  logic       res_n;
  logic       clr;
  logic [1:0] cfg;

  int n_chk  = 0;
  int n_pass = 0;

  int q_cnt  = 0;
  int q_sum  = 0;
  int lat_n  = 1;
  int exp_res = 0;
  int exp_eoc = 0;

  saradc_11b_dig_overs_acc_if #(.RESULT_MSB(10)) bus ();

  saradc_11b_dig_overs_acc #(
    .RESULT_MSB(10),
    .ACC_MSB(13)
  ) dut (
    .clk_i      (clk),
    .res_n_i    (res_n),
    .clr_i      (clr),
    .overs_cfg_i(cfg),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic cyc(
    input bit         rst,
    input bit         c,
    input bit         e,
    input int         r,
    input logic [1:0] oc,
    input string      tag
  );
    res_n        = ~rst;
    clr          = c;
    bus.eoc_i    = e;
    bus.result_i = r[10:0];
    cfg          = oc;
    @(posedge clk);
    #1;
    exp_eoc = 0;
    if (rst) begin
      q_cnt = 0; q_sum = 0; exp_res = 0; lat_n = 1;
    end else if (c) begin
      q_cnt = 0; q_sum = 0;
    end else if (e) begin
      if (q_cnt == 0) lat_n = 1 << oc;
      q_sum += r;
      q_cnt++;
      if (q_cnt == lat_n) begin
        exp_res = (q_sum + lat_n / 2) / lat_n;
        exp_eoc = 1;
        q_cnt = 0; q_sum = 0;
      end
    end
    chk({tag, ".eoc"},  int'(bus.eoc_o),     exp_eoc);
    chk({tag, ".res"},  int'(bus.result_o),  exp_res);
    chk({tag, ".busy"}, int'(bus.busy_o),    int'(q_cnt != 0));
    chk({tag, ".cnt"},  int'(bus.smp_cnt_o), q_cnt);
  endtask

  initial begin
    res_n = 1'b0; clr = 1'b0; cfg = 2'd0;
    bus.eoc_i = 1'b0; bus.result_i = '0;

    for (int i = 0; i < 3; i++) cyc(1, 0, i[0], 11'h7FF, 2'd3, "rst");
    cyc(0, 0, 0, 0, 2'd0, "idle");

    cyc(0, 0, 1, 'h5A3, 2'd0, "n1");
    cyc(0, 0, 0, 0, 2'd0, "n1_after");

    cyc(0, 0, 1, 100, 2'd2, "n4_a");
    cyc(0, 0, 1, 101, 2'd2, "n4_b");
    cyc(0, 0, 0, 0, 2'd2, "n4_gap");
    cyc(0, 0, 1, 101, 2'd2, "n4_c");
    cyc(0, 0, 1, 101, 2'd2, "n4_d");
    cyc(0, 0, 0, 0, 2'd2, "n4_after");

    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 2047, 2'd3, "n8fs");
    cyc(0, 0, 0, 0, 2'd3, "n8fs_after");

    cyc(0, 0, 1, 10, 2'd3, "cfgchg");
    cyc(0, 0, 1, 20, 2'd3, "cfgchg");
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 30 + i, 2'd0, "cfgchg");
    cyc(0, 0, 1, 777, 2'd0, "cfgchg_n1");

    cyc(0, 0, 1, 5, 2'd2, "abort_a");
    cyc(0, 0, 1, 6, 2'd2, "abort_b");
    cyc(0, 1, 1, 9, 2'd2, "abort_clr");
    cyc(0, 0, 0, 0, 2'd2, "abort_idle");
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 8, 2'd2, "abort_seq");

    cyc(0, 0, 1, 1, 2'd1, "rnd2");
    cyc(0, 0, 1, 2, 2'd1, "rnd2");
    cyc(0, 0, 1, 0, 2'd1, "rnd2");
    cyc(0, 0, 1, 1, 2'd1, "rnd2");

    for (int i = 0; i < 600; i++) begin
      automatic bit rr = ($urandom_range(0, 99) == 0);
      automatic bit cc = ($urandom_range(0, 29) == 0);
      automatic bit ee = ($urandom_range(0, 2) != 0);
      automatic int rv = ($urandom_range(0, 3) == 0) ? 2047
                         : int'($urandom_range(0, 2047));
      cyc(rr, cc, ee, rv, 2'($urandom_range(0, 3)), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
